// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcodes and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Combinational conditional two's-complement negate; gives |x| when neg_i
// carries the sign bit, and applies result sign fixup otherwise.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO: 1-bit-per-cycle shift-add
// multiply and restoring divide, with sign handling around an unsigned core.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         div_zero_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             dz_q;
  logic [W-1:0]     work_hi_q;
  logic [W-1:0]     work_lo_q;
  logic [W-1:0]     opb_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_out_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;

  logic         in_idle;
  logic         a_neg;
  logic         b_neg;
  logic         b_zero;
  logic         start_div;
  logic         neg_x_lo;
  logic         neg_x_hi;
  logic [W-1:0] x_lo;
  logic [W-1:0] x_hi;
  logic [W-1:0] y_lo;
  logic [W-1:0] y_hi;
  logic [W-1:0] iter_hi_d;
  logic [W-1:0] iter_lo_d;
  logic [W-1:0] fix_hi_d;
  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W-1:0] div_sub;
  logic         div_ge;

  assign in_idle   = (state_q == ST_IDLE);
  assign a_neg     = op_is_signed(op_i) & a_i[W-1];
  assign b_neg     = op_is_signed(op_i) & b_i[W-1];
  assign b_zero    = (b_i == '0);
  assign start_div = op_is_div(op_i);

  // The two negators are shared: operand |a|,|b| in IDLE, result fixup in FIX.
  // A divide by zero keeps the raw dividend so the remainder comes out as a.
  assign x_lo     = in_idle ? a_i : work_lo_q;
  assign neg_x_lo = in_idle ? (a_neg & ~(start_div & b_zero)) : neg_lo_q;
  assign x_hi     = in_idle ? b_i : work_hi_q;
  assign neg_x_hi = in_idle ? b_neg : (neg_hi_q & (is_div_q | (work_lo_q == '0)));

  mdu_abs_neg #(.W(W)) u_neg_lo (.x_i(x_lo), .neg_i(neg_x_lo), .y_o(y_lo));
  mdu_abs_neg #(.W(W)) u_neg_hi (.x_i(x_hi), .neg_i(neg_x_hi), .y_o(y_hi));

  // Negating a 2W product: upper half only borrows the +1 when the lower half is zero.
  assign fix_hi_d = (!is_div_q && neg_hi_q && (work_lo_q != '0)) ? ~work_hi_q : y_hi;

  assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh  = {work_hi_q, work_lo_q[W-1]};
  assign div_ge  = (div_sh >= {1'b0, opb_q});
  assign div_sub = div_sh[W-1:0] - opb_q;

  always_comb begin
    iter_hi_d = work_hi_q;
    iter_lo_d = work_lo_q;
    if (is_div_q) begin
      iter_hi_d = div_ge ? div_sub : div_sh[W-1:0];
      iter_lo_d = {work_lo_q[W-2:0], div_ge};
    end else begin
      iter_hi_d = mul_sum[W:1];
      iter_lo_d = {mul_sum[0], work_lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_q      <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opb_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            case (op_i)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                work_hi_q <= '0;
                work_lo_q <= y_lo;
                opb_q     <= y_hi;
                is_div_q  <= start_div;
                dz_q      <= start_div & b_zero;
                neg_lo_q  <= (a_neg ^ b_neg) & ~(start_div & b_zero);
                neg_hi_q  <= (start_div ? a_neg : (a_neg ^ b_neg)) & ~(start_div & b_zero);
                cnt_q     <= '0;
                busy_q    <= 1'b1;
                state_q   <= ST_CALC;
              end
              MDU_MTHI: hi_q <= a_i;
              MDU_MTLO: lo_q <= a_i;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          work_hi_q <= iter_hi_d;
          work_lo_q <= iter_lo_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q     <= fix_hi_d;
          lo_q     <= y_lo;
          done_q   <= 1'b1;
          dz_out_q <= dz_q;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_out_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed sign/latency/abort cases plus random ops
// checked against a 64-bit reference model through a result queue.
module tb_mdu_seq;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .div_zero_o(div_zero), .hi_o(hi), .lo_o(lo)
  );

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, p;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      OP_MULT: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      OP_MULTU: begin up = {32'd0, x} * {32'd0, y}; e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (y == 0) begin
          e.dz = 1'b1; e.hi = x; e.lo = 32'hFFFF_FFFF;
        end else if (o == OP_DIV) begin
          p = sx / sy; e.lo = p[31:0];
          p = sx % sy; e.hi = p[31:0];
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
    seen = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b want=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0 || div_zero !== 1'b0) $display("FAIL reset_done got=%0b/%0b want=0/0", done, div_zero); else n_pass++;
    n_total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo got=%h/%h want=0/0", hi, lo); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_multu;
    bit seen; int cyc, bc; exp_t e;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    wait_done(seen, cyc, bc);
    n_total++; if (!seen || cyc != 33) $display("FAIL multu_latency got=%0d seen=%0b want=33", cyc, seen); else n_pass++;
    e = sb.pop_front();
    n_total++; if (hi !== e.hi || lo !== e.lo) $display("FAIL multu_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); else n_pass++;
  endtask

  task automatic test_mult_signed;
    bit seen; int cyc, bc; exp_t e;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    wait_done(seen, cyc, bc);
    n_total++; if (!seen || bc != 33) $display("FAIL mult_busy_cycles got=%0d seen=%0b want=33", bc, seen); else n_pass++;
    e = sb.pop_front();
    n_total++; if (hi !== e.hi || lo !== e.lo) $display("FAIL mult_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); else n_pass++;
  endtask

  task automatic test_div;
    bit seen; int cyc, bc; exp_t e;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || hi !== e.hi || lo !== e.lo) $display("FAIL div_signed got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); else n_pass++;
    issue(OP_DIVU, 32'd7, 32'd2);
    sb.push_back('{32'd1, 32'd3, 1'b0});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || hi !== e.hi || lo !== e.lo) $display("FAIL divu got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); else n_pass++;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    sb.push_back('{32'h0, 32'h8000_0000, 1'b0});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || hi !== e.hi || lo !== e.lo || div_zero !== 1'b0) $display("FAIL div_overflow got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); else n_pass++;
  endtask

  task automatic test_div_zero;
    bit seen; int cyc, bc; exp_t e;
    issue(OP_DIVU, 32'h1234, 32'd0);
    sb.push_back('{32'h1234, 32'hFFFF_FFFF, 1'b1});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || cyc != 33) $display("FAIL divzero_latency got=%0d want=33", cyc); else n_pass++;
    n_total++; if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) $display("FAIL divu_zero got=%h/%h/%0b want=%h/%h/%0b", hi, lo, div_zero, e.hi, e.lo, e.dz); else n_pass++;
    issue(OP_DIV, 32'hFFFF_FF00, 32'd0);
    sb.push_back('{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || hi !== e.hi || lo !== e.lo || div_zero !== e.dz) $display("FAIL div_zero_signed got=%h/%h/%0b want=%h/%h/%0b", hi, lo, div_zero, e.hi, e.lo, e.dz); else n_pass++;
    @(negedge clk);
    n_total++; if (div_zero !== 1'b0 || done !== 1'b0) $display("FAIL divzero_pulse got=%0b/%0b want=0/0", div_zero, done); else n_pass++;
  endtask

  task automatic test_mthi_mtlo;
    int cyc, bad; exp_t e;
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA;
    @(negedge clk);
    n_total++; if (hi !== 32'hAAAA) $display("FAIL mthi got=%h want=0000aaaa", hi); else n_pass++;
    op = OP_MTLO; a = 32'h5555;
    @(negedge clk);
    start = 1'b0;
    n_total++; if (lo !== 32'h5555 || busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo got=%h busy=%0b done=%0b want=00005555/0/0", lo, busy, done); else n_pass++;
    issue(OP_MULT, 32'd3, 32'd5);
    sb.push_back('{32'd0, 32'd15, 1'b0});
    cyc = 0; bad = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin start = 1'b1; op = OP_MTLO; a = 32'h1234; end
      else start = 1'b0;
      if (!done && (hi !== 32'hAAAA || lo !== 32'h5555)) bad++;
    end
    start = 1'b0;
    n_total++; if (bad != 0) $display("FAIL hold_during_calc got=%0d bad cycles want=0", bad); else n_pass++;
    e = sb.pop_front();
    n_total++; if (!done || hi !== e.hi || lo !== e.lo) $display("FAIL mtlo_while_busy got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); else n_pass++;
  endtask

  task automatic test_random;
    bit seen; int cyc, bc; exp_t e;
    logic [2:0] o; logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      issue(o, x, y);
      sb.push_back(model(o, x, y));
      wait_done(seen, cyc, bc);
      e = sb.pop_front();
      n_total++;
      if (!seen || hi !== e.hi || lo !== e.lo || div_zero !== e.dz)
        $display("FAIL random_%0d op=%0d a=%h b=%h got=%h/%h/%0b want=%h/%h/%0b",
                 i, o, x, y, hi, lo, div_zero, e.hi, e.lo, e.dz);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    bit seen; int cyc, bc; exp_t e;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    sb.push_back('{32'd1, 32'd0, 1'b0});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || hi !== e.hi || lo !== e.lo) $display("FAIL b2b_first got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); else n_pass++;
    start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    @(negedge clk);
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%0b want=1", busy); else n_pass++;
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || cyc != 33 || hi !== e.hi || lo !== e.lo) $display("FAIL b2b_second got=%h/%h cyc=%0d want=%h/%h cyc=33", hi, lo, cyc, e.hi, e.lo); else n_pass++;
  endtask

  task automatic test_abort;
    bit seen; int cyc, bc; int n_done; exp_t e;
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    sb.push_back(model(OP_DIV, 32'hFFFF_FF9C, 32'd7));
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_state got busy=%0b hi=%h lo=%h want=0/0/0", busy, hi, lo); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    n_total++; if (n_done != 0) $display("FAIL abort_no_done got=%0d pulses want=0", n_done); else n_pass++;
    issue(OP_MULTU, 32'd6, 32'd7);
    sb.push_back('{32'd0, 32'd42, 1'b0});
    wait_done(seen, cyc, bc);
    e = sb.pop_front();
    n_total++; if (!seen || hi !== e.hi || lo !== e.lo) $display("FAIL after_abort got=%h/%h want=%h/%h", hi, lo, e.hi, e.lo); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_random();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
